calc_disp_drv: RTL

- Downstream stage of the calculator top level.
- Consumes the 8-bit result word and the error flag that the top level drives to the LEDs.
- Converts the result sequentially to BCD with an iterative double-dabble (shift-add-3) conversion.
- Time-multiplexes the result onto a 4-digit common-anode 7-segment display; on error it shows "Err".

---
 rtl/calc_pkg.sv | 73 +++++++
 rtl/bin2bcd_seq.sv | 111 +++++++++++
 rtl/calc_disp_drv.sv | 131 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : calc_pkg                                                   |
// | Description : Shared definitions for the calculator display driver:      |
// |               active-low 7-segment glyphs {g,f,e,d,c,b,a}, the BCD       |
// |               converter state encoding, the BCD digit-count helper and   |
// |               the digit-to-glyph decoder.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package calc_pkg;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_e;

   // Number of decimal digits needed to hold 2^bits - 1.
   function automatic int bcd_digits(input int bits);
      longint unsigned max_v;
      longint unsigned one;
      int              n;
      one   = 64'd1;
      max_v = (one << bits) - one;
      n     = 1;
      for (int i = 0; i < 20; i++) begin
         if (max_v >= 64'd10) begin
            max_v = max_v / 64'd10;
            n     = n + 1;
         end
      end
      return n;
   endfunction

   localparam int BITS_DEFAULT = 8;
   localparam int BCD_DIGITS   = bcd_digits(BITS_DEFAULT);

   // Codes 10..15 cannot come out of a correct conversion; show them blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bin2bcd_seq                                                |
// | Description : Free-running iterative double-dabble converter. Every      |
// |               conversion takes 1 IDLE (capture) + BITS SHIFT + 1 COMMIT  |
// |               cycles; the result and error flag are published together.  |
// | Ports       : clk, rst        - clock, synchronous active-high reset     |
// |               value_i, err_i  - binary input and error flag (captured    |
// |                                 in IDLE only)                            |
// |               busy_o          - high in SHIFT and COMMIT                 |
// |               bcd_o           - committed BCD digits, ones in [3:0]      |
// |               bcd_err_o       - error flag committed with bcd_o          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bin2bcd_seq
   import calc_pkg::*;
#(
   parameter int BITS = 8,
   parameter int NDIG = bcd_digits(BITS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BITS-1:0]   value_i,
   input  logic              err_i,
   output logic              busy_o,
   output logic [4*NDIG-1:0] bcd_o,
   output logic              bcd_err_o
);

   localparam int CW = $clog2(BITS + 1);

   conv_state_e       state_q,    state_d;
   logic [BITS-1:0]   bin_q,      bin_d;
   logic [4*NDIG-1:0] work_q,     work_d;
   logic [CW-1:0]     cnt_q,      cnt_d;
   logic              err_sh_q,   err_sh_d;
   logic [4*NDIG-1:0] disp_q,     disp_d;
   logic              disp_err_q, disp_err_d;
   logic [4*NDIG-1:0] work_adj;

   // Add-3 correction on every nibble >= 5 before each shift
   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_adj
         assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5)
                                    ? work_q[4*gi +: 4] + 4'd3
                                    : work_q[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         work_q     <= '0;
         cnt_q      <= '0;
         err_sh_q   <= 1'b0;
         disp_q     <= '0;
         disp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         err_sh_q   <= err_sh_d;
         disp_q     <= disp_d;
         disp_err_q <= disp_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      err_sh_d   = err_sh_q;
      disp_d     = disp_q;
      disp_err_d = disp_err_q;
      case (state_q)
         ST_IDLE: begin
            bin_d    = value_i;
            err_sh_d = err_i;
            work_d   = '0;
            cnt_d    = '0;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
            {work_d, bin_d} = {work_adj, bin_q} << 1;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == CW'(BITS - 1)) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            // Digits and error flag move together so the display never mixes sets
            disp_d     = work_q;
            disp_err_d = err_sh_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign bcd_o     = disp_q;
   assign bcd_err_o = disp_err_q;

endmodule
`default_nettype wire

// File: rtl/calc_disp_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : calc_disp_drv                                              |
// | Description : Drives the calculator result onto a 4-digit common-anode   |
// |               7-segment display. A sequential BCD converter feeds a      |
// |               time-multiplexed scan; "Err" is shown when err is set.     |
// | Options     : CALC_DISP_LZB_EN - leading-zero blanking of hundreds/tens  |
// | Ports       : clk, rst - clock, synchronous active-high reset            |
// |               value    - unsigned binary result (BITS wide)              |
// |               err      - error flag, overrides value                     |
// |               seg      - segments {g,f,e,d,c,b,a}, active-low            |
// |               dp       - decimal point, active-low, always off           |
// |               an       - digit anodes, active-low, one-hot-low           |
// |               busy     - conversion in progress                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module calc_disp_drv
   import calc_pkg::*;
#(
   parameter int SCAN_BITS = 16,
   parameter int BITS      = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] value,
   input  logic            err,
   output logic [6:0]      seg,
   output logic            dp,
   output logic [3:0]      an,
   output logic            busy
);

   localparam int NDIG = bcd_digits(BITS);
   // Only three numeric digit positions exist on the display
   localparam int DW   = (NDIG > 3) ? 4 * NDIG : 12;

   logic [4*NDIG-1:0]    conv_bcd;
   logic                 conv_err;
   logic [DW-1:0]        bcd_ext;
   logic [3:0]           ones, tens, hund;
   logic                 blank_h, blank_t;
   logic [6:0]           glyph;

   logic [SCAN_BITS-1:0] scan_q,    scan_d;
   logic [1:0]           idx_q,     idx_d;
   logic                 started_q, started_d;
   logic [6:0]           seg_q,     seg_d;
   logic [3:0]           an_q,      an_d;

   bin2bcd_seq #(
      .BITS (BITS),
      .NDIG (NDIG)
   ) u_conv (
      .clk       (clk),
      .rst       (rst),
      .value_i   (value),
      .err_i     (err),
      .busy_o    (busy),
      .bcd_o     (conv_bcd),
      .bcd_err_o (conv_err)
   );

   assign bcd_ext = DW'(conv_bcd);
   assign ones    = bcd_ext[3:0];
   assign tens    = bcd_ext[7:4];
   assign hund    = bcd_ext[11:8];

`ifdef CALC_DISP_LZB_EN
   assign blank_h = (hund == 4'd0);
   assign blank_t = blank_h && (tens == 4'd0);
`else
   assign blank_h = 1'b0;
   assign blank_t = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q    <= '0;
         idx_q     <= 2'd0;
         started_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= 4'b1111;
      end else begin
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         started_q <= started_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   always_comb begin
      scan_d    = scan_q + SCAN_BITS'(1);
      idx_d     = idx_q;
      started_d = started_q;
      // The first wrap after reset only switches the display on, so the scan
      // begins at digit 0; later wraps advance the digit.
      if (&scan_q) begin
         started_d = 1'b1;
         if (started_q) begin
            idx_d = idx_q + 2'd1;
         end
      end

      glyph = SEG_BLANK;
      if (conv_err) begin
         case (idx_q)
            2'd3:    glyph = SEG_E;
            2'd2:    glyph = SEG_R;
            2'd1:    glyph = SEG_R;
            default: glyph = SEG_BLANK;
         endcase
      end else begin
         case (idx_q)
            2'd0:    glyph = seg_decode(ones);
            2'd1:    glyph = blank_t ? SEG_BLANK : seg_decode(tens);
            2'd2:    glyph = blank_h ? SEG_BLANK : seg_decode(hund);
            default: glyph = SEG_BLANK;
         endcase
      end

      seg_d = started_q ? glyph : SEG_BLANK;
      an_d  = started_q ? ~(4'b0001 << idx_q) : 4'b1111;
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = 1'b1;

endmodule
`default_nettype wire
